// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the RV32 pipeline.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, and a missing load inserts a bubble.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stall_i) begin
      // hold everything
    end else if (load_i) begin
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_i + 32'd4;
      valid_d    = 1'b1;
    end else begin
      // bubble keeps PCD/PCPlus4D so decode still sees the last real PC
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'd0;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, BOOT/FETCH/HOLD sequencing, one-entry stall buffer.
// Optional FetchCount accept counter enabled by macro FETCH_PERF_CNT_EN.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemValid,
  input  logic [31:0] IMemRData,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] FetchCount,
`endif
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic         avail, accept;
  logic [31:0]  fetch_instr, fetch_pc;

  always_comb begin
    state_d     = state_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    IMemReq     = 1'b0;
    avail       = 1'b0;
    fetch_instr = IMemRData;
    fetch_pc    = pc_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        IMemReq = 1'b1;
        avail   = IMemValid;
        // park the response so the memory is not re-read while decode stalls
        if (IMemValid && StallD && !FlushD && !PCSrcE) begin
          buf_instr_d = IMemRData;
          buf_pc_d    = pc_q;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        avail       = 1'b1;
        fetch_instr = buf_instr_q;
        fetch_pc    = buf_pc_q;
        if (!StallD && !FlushD && !PCSrcE) state_d = FETCH;
      end
      default: state_d = BOOT;
    endcase
    if (PCSrcE) begin
      buf_instr_d = NOP_INSTR;
      buf_pc_d    = 32'd0;
      state_d     = FETCH;
    end
  end

  assign accept = avail & ~StallD & ~FlushD & ~PCSrcE;

  always_comb begin
    pc_d = pc_q;
    if (PCSrcE)      pc_d = PCTargetE;
    else if (accept) pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  assign IMemAddr = pc_q;

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .stall_i    (StallD),
    .flush_i    (FlushD),
    .load_i     (accept),
    .instr_i    (fetch_instr),
    .pc_i       (fetch_pc),
    .instr_o    (InstrD),
    .pc_o       (PCD),
    .pc_plus4_o (PCPlus4D),
    .valid_o    (ValidD)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)       fetch_cnt_q <= 32'd0;
    else if (accept) fetch_cnt_q <= fetch_cnt_q + 32'd1;
  end

  assign FetchCount = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; a second instance covers the wrapping reset PC.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, StallD, FlushD, PCSrcE, IMemValid;
  logic [31:0] PCTargetE;
  logic        IMemReq, IMemReq2;
  logic [31:0] IMemAddr, IMemAddr2, IMemRData, IMemRData2;
  logic [31:0] InstrD, PCD, PCPlus4D, InstrD2, PCD2, PCPlus4D2;
  logic        ValidD, ValidD2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount, FetchCount2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      default: return 32'h1000_0000 | a;
    endcase
  endfunction

  assign IMemRData  = mem_word(IMemAddr);
  assign IMemRData2 = mem_word(IMemAddr2);

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .IMemReq   (IMemReq),
    .IMemAddr  (IMemAddr),
    .IMemValid (IMemValid),
    .IMemRData (IMemRData),
`ifdef FETCH_PERF_CNT_EN
    .FetchCount(FetchCount),
`endif
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk       (clk),
    .reset     (reset),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .IMemReq   (IMemReq2),
    .IMemAddr  (IMemAddr2),
    .IMemValid (IMemValid),
    .IMemRData (IMemRData2),
`ifdef FETCH_PERF_CNT_EN
    .FetchCount(FetchCount2),
`endif
    .InstrD    (InstrD2),
    .PCD       (PCD2),
    .PCPlus4D  (PCPlus4D2),
    .ValidD    (ValidD2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'h0; IMemValid = 1'b1;
    tick(); tick();
    check_eq("rst_req", {31'd0, IMemReq}, 32'd0);
    check_eq("rst_addr", IMemAddr, 32'h0);
    check_eq("rst_instr", InstrD, 32'h0000_0013);
    check_eq("rst_valid", {31'd0, ValidD}, 32'd0);
    check_eq("rst_pcd", PCD, 32'h0);
    check_eq("rst_pc4", PCPlus4D, 32'h0);
    check_eq("rst_w_addr", IMemAddr2, 32'hFFFF_FFFC);

    reset = 1'b0;
    check_eq("boot_req", {31'd0, IMemReq}, 32'd0);
    tick();
    check_eq("fetch_req", {31'd0, IMemReq}, 32'd1);
    check_eq("fetch_addr0", IMemAddr, 32'h0);
    check_eq("boot_no_valid", {31'd0, ValidD}, 32'd0);

    tick();
    check_eq("i0_instr", InstrD, 32'h0050_0093);
    check_eq("i0_pcd", PCD, 32'h0);
    check_eq("i0_pc4", PCPlus4D, 32'h4);
    check_eq("i0_valid", {31'd0, ValidD}, 32'd1);
    check_eq("i0_addr", IMemAddr, 32'h4);
    check_eq("wrap_pcd", PCD2, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", PCPlus4D2, 32'h0);
    check_eq("wrap_addr", IMemAddr2, 32'h0);

    tick();
    check_eq("i1_instr", InstrD, 32'h00A0_0113);
    check_eq("i1_pcd", PCD, 32'h4);
    check_eq("i1_addr", IMemAddr, 32'h8);

    // stall three cycles with the word at 8 already on the bus
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_req", {31'd0, IMemReq}, 32'd0);
      check_eq("stall_addr", IMemAddr, 32'h8);
      check_eq("stall_instr", InstrD, 32'h00A0_0113);
      check_eq("stall_pcd", PCD, 32'h4);
    end
    StallD = 1'b0;
    tick();
    check_eq("unstall_instr", InstrD, 32'h1000_0008);
    check_eq("unstall_pcd", PCD, 32'h8);
    check_eq("unstall_addr", IMemAddr, 32'hC);
    check_eq("unstall_req", {31'd0, IMemReq}, 32'd1);

    IMemValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("wait_addr", IMemAddr, 32'hC);
      check_eq("wait_req", {31'd0, IMemReq}, 32'd1);
      check_eq("wait_valid", {31'd0, ValidD}, 32'd0);
      check_eq("wait_instr", InstrD, 32'h0000_0013);
      check_eq("wait_pcd", PCD, 32'h8);
    end
    IMemValid = 1'b1;
    tick();
    check_eq("resume_instr", InstrD, 32'h1000_000C);
    check_eq("resume_addr", IMemAddr, 32'h10);
    repeat (4) tick();
    check_eq("pc20", IMemAddr, 32'h20);

    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h100;
    tick();
    PCSrcE = 1'b0; FlushD = 1'b0;
    check_eq("redir_addr", IMemAddr, 32'h100);
    check_eq("redir_valid", {31'd0, ValidD}, 32'd0);
    check_eq("redir_instr", InstrD, 32'h0000_0013);
    check_eq("redir_pcd", PCD, 32'h1C);
    tick();
    check_eq("tgt_instr", InstrD, 32'h1000_0100);
    check_eq("tgt_pcd", PCD, 32'h100);
    check_eq("tgt_valid", {31'd0, ValidD}, 32'd1);

    // flush beats stall: bubble, no capture into the buffer
    FlushD = 1'b1; StallD = 1'b1;
    tick();
    FlushD = 1'b0; StallD = 1'b0;
    check_eq("fs_valid", {31'd0, ValidD}, 32'd0);
    check_eq("fs_req", {31'd0, IMemReq}, 32'd1);
    check_eq("fs_addr", IMemAddr, 32'h104);
    tick();
    check_eq("fs_next_instr", InstrD, 32'h1000_0104);

    StallD = 1'b1;
    tick();
    check_eq("hold_req", {31'd0, IMemReq}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0; StallD = 1'b0;
    check_eq("hrst_req", {31'd0, IMemReq}, 32'd0);
    check_eq("hrst_addr", IMemAddr, 32'h0);
    check_eq("hrst_valid", {31'd0, ValidD}, 32'd0);
    check_eq("hrst_instr", InstrD, 32'h0000_0013);
`ifdef FETCH_PERF_CNT_EN
    check_eq("cnt_rst", FetchCount, 32'd0);
`endif
    tick();
    check_eq("hrst_fetch_req", {31'd0, IMemReq}, 32'd1);
    tick();
    check_eq("hrst_instr0", InstrD, 32'h0050_0093);
    check_eq("hrst_pcd0", PCD, 32'h0);
    repeat (9) tick();
    check_eq("ten_addr", IMemAddr, 32'h28);
    check_eq("ten_pcd", PCD, 32'h24);
`ifdef FETCH_PERF_CNT_EN
    check_eq("cnt_ten", FetchCount, 32'd10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 StallD  in  1  decode stage cannot accept; IF/ID register and PC hold.
REQ-005 FlushD  in  1  kill IF/ID contents (insert bubble).
REQ-006 PCSrcE  in  1  redirect request from execute (taken branch/jump).
REQ-007 PCTargetE  in  32  redirect target address.
REQ-008 IMemReq  out  1  instruction fetch request.
REQ-009 IMemAddr  out  32  fetch address; equals PCF.
REQ-010 IMemValid  in  1  IMemRData holds the word at IMemAddr this cycle.
REQ-011 IMemRData  in  32  instruction word.
REQ-012 InstrD  out  32  IF/ID instruction, consumed by decode and immediate extension.
REQ-013 PCD  out  32  IF/ID PC of InstrD.
REQ-014 PCPlus4D  out  32  IF/ID PCD+4.
REQ-015 ValidD  out  1  InstrD is a real instruction, not a bubble.

Function
REQ-016 FSM states SHALL be BOOT, FETCH, HOLD.
REQ-017 BOOT: IMemReq=0; next state FETCH unconditionally; lasts exactly one cycle after reset release.
REQ-018 FETCH: IMemReq=1; instruction available (avail) when IMemValid=1.
REQ-019 HOLD: IMemReq=0; avail=1 from one-entry buffer {BufInstr, BufPC}.
REQ-020 accept = avail & ~StallD & ~FlushD & ~PCSrcE.
REQ-021 FETCH, IMemValid=1, StallD=1, PCSrcE=0, FlushD=0: capture IMemRData and PCF into buffer; go to HOLD.
REQ-022 HOLD with StallD=0, FlushD=0, PCSrcE=0: load IF/ID from buffer; go to FETCH.
REQ-023 PC priority: reset -> RESET_PC; PCSrcE -> PCTargetE; accept -> PCF+4 (mod 2^32, wraps 32'hFFFF_FFFC to 0); else hold.
REQ-024 PCSrcE=1 in any state SHALL discard the buffer and the current response and force next state FETCH.
REQ-025 IF/ID priority: reset or FlushD -> bubble; StallD -> hold; accept -> {IMemRData or BufInstr, PC, PC+4, ValidD=1}; else -> bubble.
REQ-026 Bubble SHALL be InstrD=32'h0000_0013 (addi x0,x0,0), ValidD=0, PCD and PCPlus4D unchanged.
REQ-027 Fetch-to-decode latency SHALL be one cycle: word accepted in cycle N appears on InstrD in cycle N+1.
REQ-028 FlushD and StallD both high: flush wins.
REQ-029 PCSrcE and FlushD both high: PC takes PCTargetE, IF/ID bubbles.

Reset
REQ-030 On reset: PCF=RESET_PC, state=BOOT, buffer cleared, InstrD=32'h0000_0013, PCD=0, PCPlus4D=0, ValidD=0, IMemReq=0.
REQ-031 Reset asserted mid-FETCH or mid-HOLD SHALL discard any pending/buffered instruction.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN: when defined, add output FetchCount (32 bits), reset 0, +1 on each accept, wraps at 2^32.
REQ-033 Without FETCH_PERF_CNT_EN: port and counter absent; all other behaviour identical.

Structure
REQ-034 Shared package riscv_pkg SHALL hold NOP_INSTR constant and fetch_state_t enum {BOOT, FETCH, HOLD}.
REQ-035 One sub-module if_id_reg (IF/ID register with stall/flush) SHALL be instantiated; PC logic and FSM stay in fetch_stage.

Verification
REQ-036 Reset release, IMemValid=1 each cycle, words 0x00500093, 0x00A00113 -> IMemAddr 0,4,...; InstrD=0x00500093/PCD=0 then 0x00A00113/PCD=4, ValidD=1.
REQ-037 StallD=1 for 3 cycles while IMemValid=1 at PC=8 -> state HOLD, IMemReq=0, PCF stays 8, IF/ID unchanged; after release InstrD=word@8, PCD=8, PCF=12.
REQ-038 PCSrcE=1, PCTargetE=0x100, FlushD=1 at PC=0x20 -> next IMemAddr=0x100, ValidD=0, InstrD=0x00000013; following cycle InstrD=word@0x100.
REQ-039 IMemValid=0 for 4 cycles in FETCH -> PCF held, IMemReq=1, ValidD=0 bubbles each cycle.
REQ-040 RESET_PC=32'hFFFF_FFFC, one accept -> PCD=0xFFFFFFFC, PCPlus4D=0, next IMemAddr=0.
REQ-041 Reset in HOLD with StallD=1 -> next cycle state BOOT, ValidD=0, PCF=RESET_PC; FETCH_PERF_CNT_EN build: FetchCount=0 after reset, equals accept count after 10 fetches.
